// File: rtl/vga_sync_decoder.sv
// Sink-side VGA sync decoder: measures incoming hSync/vSync timing, locks onto
// the configured mode and regenerates active-area pixel coordinates.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 128,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 521,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 31,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hSyncIn,
  input  logic       vSyncIn,
  output logic [9:0] xPos,
  output logic [9:0] yPos,
  output logic       pixelValid,
  output logic       frameStart,
  output logic       locked,
  output logic       syncError,
  output logic [9:0] lineLength,
  output logic [9:0] frameLines
);

  localparam logic [9:0] CNT_MAX     = 10'd1023;
  localparam logic [9:0] H_TOTAL_C   = 10'(H_TOTAL);
  localparam logic [9:0] H_SYNC_C    = 10'(H_SYNC);
  localparam logic [9:0] H_ACT_S_C   = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_E_C   = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0] V_TOTAL_C   = 10'(V_TOTAL);
  localparam logic [9:0] V_SYNC_C    = 10'(V_SYNC);
  localparam logic [9:0] V_ACT_S_C   = 10'(V_ACT_START);
  localparam logic [9:0] V_ACT_E_C   = 10'(V_ACT_START + V_ACTIVE);
  localparam logic [7:0] LOCK_C      = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  function automatic logic [9:0] satInc(input logic [9:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 10'd1;
  endfunction

  logic       hS1_q, hS2_q, vS1_q, vS2_q;
  logic       hFall, vFall;
  logic [9:0] col_q, col_d, colInc;
  logic [9:0] line_q, line_d, lineInc;
  logic [9:0] hLow_q, hLow_d, vLow_q, vLow_d;
  logic       lineErr, frameErr, anyErr;
  state_e     state_q, state_d;
  logic [7:0] good_q, good_d;
  logic       pixelValid_q, pixelValid_d, frameStart_q, frameStart_d;
  logic       locked_q, locked_d, syncError_q, syncError_d;
  logic [9:0] xPos_q, xPos_d, yPos_q, yPos_d;
  logic [9:0] lineLength_q, lineLength_d, frameLines_q, frameLines_d;

  // Reset to the idle-high level so releasing reset never looks like a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hS1_q <= 1'b1;
      hS2_q <= 1'b1;
      vS1_q <= 1'b1;
      vS2_q <= 1'b1;
    end else begin
      hS1_q <= hSyncIn;
      hS2_q <= hS1_q;
      vS1_q <= vSyncIn;
      vS2_q <= vS1_q;
    end
  end

  assign hFall = hS2_q & ~hS1_q;
  assign vFall = vS2_q & ~vS1_q;

  always_comb begin
    colInc  = satInc(col_q);
    col_d   = hFall ? 10'd0 : colInc;
    lineInc = hFall ? satInc(line_q) : line_q;
    line_d  = vFall ? 10'd0 : lineInc;
    hLow_d  = hFall ? 10'd1 : (!hS1_q ? satInc(hLow_q) : hLow_q);
    vLow_d  = vFall ? 10'd1 : ((hFall && !vS1_q) ? satInc(vLow_q) : vLow_q);
    // Timeouts fire only on the cycle the counter crosses the limit, so once.
    lineErr  = hFall ? ((colInc != H_TOTAL_C) || (hLow_q != H_SYNC_C))
                     : (col_q == CNT_MAX - 10'd1);
    frameErr = vFall ? ((lineInc != V_TOTAL_C) || (vLow_q != V_SYNC_C))
                     : (hFall && (line_q == V_TOTAL_C));
    anyErr   = lineErr | frameErr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      line_q <= '0;
      hLow_q <= '0;
      vLow_q <= '0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
      hLow_q <= hLow_d;
      vLow_q <= vLow_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (vFall) begin
          state_d = MEASURE;
          good_d  = '0;
        end
      end
      MEASURE: begin
        if (anyErr) begin
          state_d = SEARCH;
        end else if (vFall) begin
          good_d = good_q + 8'd1;
          if (good_q + 8'd1 >= LOCK_C) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (anyErr) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  // Outputs are computed from the next state so lock changes land with the
  // same two-clock latency as the pixel coordinates.
  always_comb begin
    locked_d     = (state_d == LOCKED);
    pixelValid_d = locked_d &&
                   (col_d >= H_ACT_S_C) && (col_d < H_ACT_E_C) &&
                   (line_d >= V_ACT_S_C) && (line_d < V_ACT_E_C);
    xPos_d       = pixelValid_d ? col_d - H_ACT_S_C : 10'd0;
    yPos_d       = pixelValid_d ? line_d - V_ACT_S_C : 10'd0;
    frameStart_d = pixelValid_d && (col_d == H_ACT_S_C) && (line_d == V_ACT_S_C);
    syncError_d  = (state_q == LOCKED) && anyErr;
    lineLength_d = hFall ? colInc : lineLength_q;
    frameLines_d = vFall ? lineInc : frameLines_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixelValid_q <= 1'b0;
      frameStart_q <= 1'b0;
      locked_q     <= 1'b0;
      syncError_q  <= 1'b0;
      xPos_q       <= '0;
      yPos_q       <= '0;
      lineLength_q <= '0;
      frameLines_q <= '0;
    end else begin
      pixelValid_q <= pixelValid_d;
      frameStart_q <= frameStart_d;
      locked_q     <= locked_d;
      syncError_q  <= syncError_d;
      xPos_q       <= xPos_d;
      yPos_q       <= yPos_d;
      lineLength_q <= lineLength_d;
      frameLines_q <= frameLines_d;
    end
  end

  assign pixelValid = pixelValid_q;
  assign frameStart = frameStart_q;
  assign locked     = locked_q;
  assign syncError  = syncError_q;
  assign xPos       = xPos_q;
  assign yPos       = yPos_q;
  assign lineLength = lineLength_q;
  assign frameLines = frameLines_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder using a reduced video mode so that many
// frames, faults and relocks fit in a short run.
module tb_vga_sync_decoder;

  localparam int H_TOTAL     = 40;
  localparam int H_SYNC      = 6;
  localparam int H_ACT_START = 10;
  localparam int H_ACTIVE    = 24;
  localparam int V_TOTAL     = 21;
  localparam int V_SYNC      = 2;
  localparam int V_ACT_START = 4;
  localparam int V_ACTIVE    = 12;
  localparam int LOCK_FRAMES = 2;

  typedef struct packed {
    logic       pv;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic       lk;
    logic       se;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hSyncIn = 1'b1;
  logic       vSyncIn = 1'b1;
  logic [9:0] xPos, yPos, lineLength, frameLines;
  logic       pixelValid, frameStart, locked, syncError;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   bState = 0;
  int   bGood = 0;
  bit   pendFrameErr = 1'b0;
  bit   prevLineErr = 1'b0;
  int   rstHold = 0;
  int   pvCount = 0;
  int   fsCount = 0;

  vga_sync_decoder #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_ACT_START(H_ACT_START),
    .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
    .V_ACT_START(V_ACT_START), .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
    .xPos(xPos), .yPos(yPos), .pixelValid(pixelValid), .frameStart(frameStart),
    .locked(locked), .syncError(syncError), .lineLength(lineLength),
    .frameLines(frameLines)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  // Drives one pixel sample, pushes its expected outputs and compares the
  // sample that the DUT is presenting now.
  task automatic applyStimulus(input logic h, input logic v, input bit isVFall,
                               input bit errS, input int col, input int line);
    exp_t e;
    exp_t got;
    hSyncIn = h;
    vSyncIn = v;
    if (rstHold > 0) begin
      reset = 1'b1;
      rstHold--;
      expQ.delete();
      bState = 0;
      bGood = 0;
      pendFrameErr = 1'b0;
      #1;
      checkOutput("resetOutputs",
                  64'({pixelValid, xPos, yPos, frameStart, locked, syncError, lineLength, frameLines}),
                  64'd0);
      @(posedge clk);
      #1;
      return;
    end
    reset = 1'b0;
    e = '0;
    if (errS && bState != 0) begin
      e.se = (bState == 2);
      bState = 0;
    end else if (isVFall) begin
      if (bState == 0) begin
        bState = 1;
        bGood = 0;
      end else if (bState == 1) begin
        bGood++;
        if (bGood == LOCK_FRAMES) bState = 2;
      end
    end
    e.lk = (bState == 2);
    e.pv = e.lk && col >= H_ACT_START && col < H_ACT_START + H_ACTIVE &&
           line >= V_ACT_START && line < V_ACT_START + V_ACTIVE;
    e.x  = e.pv ? 10'(col - H_ACT_START) : 10'd0;
    e.y  = e.pv ? 10'(line - V_ACT_START) : 10'd0;
    e.fs = e.pv && col == H_ACT_START && line == V_ACT_START;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() >= 2) begin
      got = {pixelValid, xPos, yPos, frameStart, locked, syncError};
      checkOutput("cycleOutputs", 64'(got), 64'(expQ.pop_front()));
      if (pixelValid) pvCount++;
      if (frameStart) fsCount++;
    end
  endtask

  // One frame of source timing with optional faults; -1 disables a fault.
  task automatic genFrame(input int vsw, input int longLine, input int longLen,
                          input int shortLine, input int shortW,
                          input int rstLine, input int rstCol);
    for (int line = 0; line < V_TOTAL; line++) begin
      int len;
      int hw;
      len = (line == longLine) ? longLen : H_TOTAL;
      hw  = (line == shortLine) ? shortW : H_SYNC;
      for (int col = 0; col < len; col++) begin
        bit errS;
        errS = 1'b0;
        if (col == 0 && prevLineErr) errS = 1'b1;
        if (col == 0 && line == 0 && pendFrameErr) errS = 1'b1;
        if (col == 1023) errS = 1'b1;
        if (line == rstLine && col == rstCol) rstHold = 3;
        applyStimulus(col >= hw, line >= vsw, (line == 0 && col == 0), errS, col, line);
        if (col == 0 && line == 0) pendFrameErr = 1'b0;
        if (longLine >= 0 && line == longLine + 1 && col == 2) begin
          checkOutput("lineLenLong", 64'(lineLength), 64'(longLen > 1023 ? 1023 : longLen));
          checkOutput("lockLostLong", 64'(locked), 64'd0);
        end
      end
      prevLineErr = (len != H_TOTAL) || (hw != H_SYNC);
    end
    pendFrameErr = (vsw != V_SYNC);
  endtask

  task automatic cleanFrames(input int n);
    for (int i = 0; i < n; i++) genFrame(V_SYNC, -1, 0, -1, 0, -1, -1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetInit",
                64'({pixelValid, xPos, yPos, frameStart, locked, syncError, lineLength, frameLines}),
                64'd0);

    // Acquisition from reset, then one fully checked locked frame.
    cleanFrames(3);
    checkOutput("lockedInit", 64'(locked), 64'd1);
    checkOutput("lineLength", 64'(lineLength), 64'(H_TOTAL));
    checkOutput("frameLines", 64'(frameLines), 64'(V_TOTAL));
    pvCount = 0;
    fsCount = 0;
    cleanFrames(1);
    checkOutput("pixelCount", 64'(pvCount), 64'(H_ACTIVE * V_ACTIVE));
    checkOutput("frameStarts", 64'(fsCount), 64'd1);

    // One line one clock too long.
    genFrame(V_SYNC, 8, H_TOTAL + 1, -1, 0, -1, -1);
    cleanFrames(3);
    checkOutput("relockLong", 64'(locked), 64'd1);

    // hSync held high long enough to hit the column timeout.
    genFrame(V_SYNC, 8, 1100, -1, 0, -1, -1);
    cleanFrames(3);
    checkOutput("relockHold", 64'(locked), 64'd1);

    // vSync pulse one line too wide.
    genFrame(V_SYNC + 1, -1, 0, -1, 0, -1, -1);
    cleanFrames(1);
    checkOutput("lockLostWide", 64'(locked), 64'd0);
    checkOutput("frameLinesWide", 64'(frameLines), 64'(V_TOTAL));
    cleanFrames(3);
    checkOutput("relockWide", 64'(locked), 64'd1);

    // Reset mid-frame inside the active area.
    genFrame(V_SYNC, -1, 0, -1, 0, 8, 20);
    cleanFrames(2);
    checkOutput("noLockTwoFalls", 64'(locked), 64'd0);
    cleanFrames(1);
    checkOutput("relockReset", 64'(locked), 64'd1);

    // Short hSync pulse while measuring delays lock by one frame.
    genFrame(V_SYNC, -1, 0, -1, 0, 8, 20);
    genFrame(V_SYNC, -1, 0, 5, H_SYNC - 1, -1, -1);
    cleanFrames(2);
    checkOutput("noLockShort", 64'(locked), 64'd0);
    cleanFrames(1);
    checkOutput("relockShort", 64'(locked), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Sink-side counterpart of the VGA sync generator. Samples an incoming active-low hSync/vSync pair on the pixel clock, measures line and frame timing, and locks once timing matches the configured mode. Once locked, it regenerates active-area pixel coordinates for downstream capture and checking logic. It is used in loopback self-test and to qualify externally supplied sync streams.

## Interface
- H_TOTAL, 800, pixel clocks per line
- H_SYNC, 128, hSync low width in clocks
- H_ACT_START, 144, first active column (clocks after hSync fall)
- H_ACTIVE, 640, active columns
- V_TOTAL, 521, lines per frame
- V_SYNC, 2, vSync low width in lines
- V_ACT_START, 31, first active line (lines after the vSync line)
- V_ACTIVE, 480, active lines
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- clk  in  1  pixel clock, same domain as the sync source
- reset  in  1  asynchronous, active-high
- hSyncIn  in  1  horizontal sync, active low
- vSyncIn  in  1  vertical sync, active low
- xPos  out  10  active column 0..H_ACTIVE-1; 0 when pixelValid=0
- yPos  out  10  active line 0..V_ACTIVE-1; 0 when pixelValid=0
- pixelValid  out  1  sample is inside the active area and the block is locked
- frameStart  out  1  1-cycle pulse with pixel (0,0)
- locked  out  1  timing lock
- syncError  out  1  1-cycle pulse on any timing violation
- lineLength  out  10  last measured hSync-fall-to-fall period, saturates at 1023
- frameLines  out  10  last measured line count between vSync falls, saturates at 1023

## Operation
- Inputs pass through 2 registers. Edge detectors use the idle-high value (1) at reset, so no false edge is seen when reset is released.
- H count: column 0 is the sample where hSync first reads low. The count increments per clock and saturates at 1023.
- Line index: the line whose hSync fall is followed, within that same line, by a vSync fall is line 0. The count increments on each hSync fall and saturates at 1023.
- Active area: column in [H_ACT_START, H_ACT_START+H_ACTIVE) and line in [V_ACT_START, V_ACT_START+V_ACTIVE). xPos = column-H_ACT_START. yPos = line-V_ACT_START.
- Line checks, evaluated at each hSync fall for the line just ended:
  - period == H_TOTAL
  - hSync low width == H_SYNC
- Column timeout: column reaching 1023 is an immediate line error, reported once.
- Frame checks, evaluated at each vSync fall:
  - frameLines == V_TOTAL
  - vSync low width == V_SYNC lines (count of hSync falls while vSync is low, including the vSync line)
- Line timeout: a line count exceeding V_TOTAL without a vSync fall is an immediate frame error.
- FSM:
  - SEARCH: waits for a vSync fall, then goes to MEASURE with goodFrames=0.
  - MEASURE: any error → SEARCH. Each vSync fall with a clean frame increments goodFrames. When goodFrames reaches LOCK_FRAMES → LOCKED.
  - LOCKED: any line or frame error → syncError pulse, locked=0, state SEARCH. Counters keep running, so reacquisition starts at the next vSync fall.
- syncError pulses only in LOCKED. Errors in MEASURE restart silently.
- lineLength and frameLines update at every respective edge in all states.
- A vSync fall that ends a frame also starts the next frame's measurement.

## Timing
- Fixed latency 2 clocks: outputs in cycle t describe the input sample at cycle t-2. This applies to pixelValid, xPos, yPos, frameStart, locked transitions and syncError.
- Reset values: xPos=0, yPos=0, pixelValid=0, frameStart=0, locked=0, syncError=0, lineLength=0, frameLines=0. FSM=SEARCH, goodFrames=0, counters=0.
- Reset asserted mid-frame clears all outputs immediately (asynchronous). A full reacquisition of LOCK_FRAMES+1 vSync falls is required afterwards.
- locked rises in the same cycle as the first pixelValid-eligible frame boundary, i.e. 2 clocks after the locking vSync fall.
- Simultaneous line error and frame error: a single syncError pulse.

## Test plan
- Standard 800×521 source from reset: locked=1 two clocks after the 3rd vSync fall; lineLength=800, frameLines=521. Per subsequent frame: exactly 307200 pixelValid cycles, one frameStart. First pixelValid lands at column 144, line 31, with xPos=0, yPos=0.
- While locked, one line lengthened to 801 clocks: at that line's closing hSync fall +2, syncError pulses once, locked=0, lineLength=801. Relock after 3 further clean vSync falls.
- While locked, hSync held high: syncError once when the column reaches 1023, lineLength saturates to 1023 at the next fall, and pixelValid stays 0.
- vSync pulse width 3 lines while locked: syncError at the next vSync fall, locked=0, frameLines=521.
- hSync low width 127 during MEASURE: no syncError, locked stays 0, state returns to SEARCH. Lock is delayed by one extra frame relative to the clean case.
- reset pulsed at line 200, column 300 while locked: all outputs 0 during reset. Relock only after 3 vSync falls post-release, with no spurious syncError.
